// File: rtl/fuzz_irq_receiver.sv
// rtl/fuzz_irq_receiver.sv - receives the harness stall/watchdog interrupt level and raises a
// sticky, maskable interrupt with coverage snapshot, event count and a 1-cycle register port.
module fuzz_irq_receiver #(
   parameter int COV_W   = 30,
   parameter int HOLDOFF = 64,
   parameter int CNT_W   = 32
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             irq_in,
   input  logic [COV_W-1:0] cov,
   input  logic             tohost_done,
   input  logic             req_valid,
   input  logic             req_write,
   input  logic [1:0]       req_addr,
   input  logic [63:0]      req_wdata,
   output logic             resp_valid,
   output logic [63:0]      resp_rdata,
   output logic             irq_out
);

   localparam int HC_W = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_PENDING = 2'd1,
      ST_HOLDOFF = 2'd2
   } state_t;

   state_t           state, state_next;
   logic [HC_W-1:0]  hcnt, hcnt_next;
   logic [CNT_W-1:0] count;
   logic [COV_W-1:0] cov_snap;
   logic             enable, enable_next;
   logic             s1, s2, s3;
   logic             rise, take_edge;
   logic             clear_wr, ctrl_wr;
   logic [63:0]      rdata;

   // s3 resets low, so a line already high at reset release still yields one edge
   assign rise     = s2 & ~s3;
   assign clear_wr = req_valid & req_write & (req_addr == 2'd3);
   assign ctrl_wr  = req_valid & req_write & (req_addr == 2'd2);

   always_comb begin
      state_next = state;
      hcnt_next  = hcnt;
      take_edge  = 1'b0;
      case (state)
         ST_IDLE: begin
            if (rise) begin
               state_next = ST_PENDING;
               take_edge  = 1'b1;
            end
         end
         ST_PENDING: begin
            if (clear_wr || tohost_done) begin
               state_next = ST_HOLDOFF;
               hcnt_next  = HC_W'(HOLDOFF - 1);
            end
         end
         ST_HOLDOFF: begin
            if (clear_wr) begin
               hcnt_next = HC_W'(HOLDOFF - 1);
            end else if (hcnt == '0) begin
               state_next = ST_IDLE;
            end else begin
               hcnt_next = hcnt - HC_W'(1);
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   assign enable_next = ctrl_wr ? req_wdata[0] : enable;

   // Read mux reflects pre-update state; writes always return zero
   always_comb begin
      rdata = '0;
      if (!req_write) begin
         case (req_addr)
            2'd0: begin
               rdata[32 +: CNT_W] = count;
               rdata[3]           = enable;
               rdata[2:1]         = state;
               rdata[0]           = (state == ST_PENDING);
            end
            2'd1:    rdata[COV_W-1:0] = cov_snap;
            2'd2:    rdata[0] = enable;
            default: rdata = '0;
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
         s3 <= 1'b0;
      end else begin
         s1 <= irq_in;
         s2 <= s1;
         s3 <= s2;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state <= ST_IDLE;
         hcnt  <= '0;
      end else begin
         state <= state_next;
         hcnt  <= hcnt_next;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         count      <= '0;
         cov_snap   <= '0;
         enable     <= 1'b1;
         irq_out    <= 1'b0;
         resp_valid <= 1'b0;
         resp_rdata <= '0;
      end else begin
         if (ctrl_wr && req_wdata[1]) begin
            count <= take_edge ? CNT_W'(1) : '0;
         end else if (take_edge) begin
            count <= count + CNT_W'(1);
         end
         if (take_edge) begin
            cov_snap <= cov;
         end
         enable     <= enable_next;
         irq_out    <= (state_next == ST_PENDING) && enable_next;
         resp_valid <= req_valid;
         resp_rdata <= req_valid ? rdata : '0;
      end
   end

endmodule

// File: tb/tb_fuzz_irq_receiver.sv
// tb/tb_fuzz_irq_receiver.sv - directed bench for fuzz_irq_receiver with a read-data scoreboard.
module tb_fuzz_irq_receiver;

   localparam int HOLD = 64;

   logic        clock = 1'b0;
   logic        reset_n;
   logic        irq_in;
   logic [29:0] cov;
   logic        tohost_done;
   logic        req_valid;
   logic        req_write;
   logic [1:0]  req_addr;
   logic [63:0] req_wdata;
   logic        resp_valid;
   logic [63:0] resp_rdata;
   logic        irq_out;

   int          tests = 0;
   int          fails = 0;
   logic [63:0] exp_q[$];

   always #5 clock = ~clock;

   fuzz_irq_receiver #(.COV_W(30), .HOLDOFF(HOLD), .CNT_W(4)) dut (
      .clock       (clock),
      .reset_n     (reset_n),
      .irq_in      (irq_in),
      .cov         (cov),
      .tohost_done (tohost_done),
      .req_valid   (req_valid),
      .req_write   (req_write),
      .req_addr    (req_addr),
      .req_wdata   (req_wdata),
      .resp_valid  (resp_valid),
      .resp_rdata  (resp_rdata),
      .irq_out     (irq_out)
   );

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   // STATUS word: count in the upper half, {enable,state,pending} in the low nibble
   function automatic logic [63:0] st(input int c, input logic [3:0] low);
      logic [31:0] cw;
      cw = c;
      return {cw, 28'd0, low};
   endfunction

   task automatic reg_op(input logic wr, input logic [1:0] a, input logic [63:0] wd,
                         input logic [63:0] exp, input string tag);
      logic [63:0] e;
      req_valid = 1'b1;
      req_write = wr;
      req_addr  = a;
      req_wdata = wd;
      exp_q.push_back(wr ? 64'd0 : exp);
      tick();
      req_valid = 1'b0;
      req_write = 1'b0;
      req_wdata = '0;
      check({tag, "_valid"}, {63'd0, resp_valid}, 64'd1);
      e = exp_q.pop_front();
      check(tag, resp_rdata, e);
   endtask

   task automatic clear_irq();
      reg_op(1'b1, 2'd3, 64'd0, 64'd0, "clear_wr");
   endtask

   task automatic drain();
      repeat (HOLD + 2) tick();
   endtask

   task automatic pulse_edge();
      irq_in = 1'b0;
      repeat (3) tick();
      irq_in = 1'b1;
      repeat (3) tick();
   endtask

   initial begin
      reset_n = 1'b0; irq_in = 1'b0; cov = '0; tohost_done = 1'b0;
      req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
      repeat (2) tick();
      check("rst_irq", {63'd0, irq_out}, 64'd0);
      check("rst_rv", {63'd0, resp_valid}, 64'd0);
      check("rst_rd", resp_rdata, 64'd0);
      reset_n = 1'b1;
      tick();
      reg_op(1'b0, 2'd0, 64'd0, st(0, 4'h8), "status_reset");
      tick();
      check("rv_idle", {63'd0, resp_valid}, 64'd0);

      // rising edge: irq_out on the third clock edge after the input rises
      cov = 30'h1234;
      irq_in = 1'b1;
      repeat (2) tick();
      check("edge_early", {63'd0, irq_out}, 64'd0);
      tick();
      check("edge_irq", {63'd0, irq_out}, 64'd1);
      cov = 30'h3FFF_FFFF;
      reg_op(1'b0, 2'd1, 64'd0, 64'h1234, "covsnap1");
      reg_op(1'b0, 2'd0, 64'd0, st(1, 4'hB), "status1");

      // clear, ignored pulse inside holdoff, exact holdoff length
      clear_irq();
      check("clear_irq", {63'd0, irq_out}, 64'd0);
      reg_op(1'b0, 2'd0, 64'd0, st(1, 4'hC), "status_hold");
      irq_in = 1'b0;
      repeat (3) tick();
      irq_in = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         check("hold_pulse", {63'd0, irq_out}, 64'd0);
      end
      irq_in = 1'b0;
      for (int i = 0; i < 53; i++) begin
         tick();
         check("hold_quiet", {63'd0, irq_out}, 64'd0);
      end
      reg_op(1'b0, 2'd0, 64'd0, st(1, 4'hC), "hold_last");
      reg_op(1'b0, 2'd0, 64'd0, st(1, 4'h8), "hold_exit");
      irq_in = 1'b1;
      repeat (3) tick();
      check("second_irq", {63'd0, irq_out}, 64'd1);
      reg_op(1'b0, 2'd0, 64'd0, st(2, 4'hB), "status2");

      // tohost_done together with CLEAR: a single holdoff entry
      tohost_done = 1'b1;
      clear_irq();
      tohost_done = 1'b0;
      check("both_irq", {63'd0, irq_out}, 64'd0);
      repeat (HOLD - 1) tick();
      reg_op(1'b0, 2'd0, 64'd0, st(2, 4'hC), "both_last");
      reg_op(1'b0, 2'd0, 64'd0, st(2, 4'h8), "both_exit");

      // tohost_done alone
      pulse_edge();
      check("third_irq", {63'd0, irq_out}, 64'd1);
      tohost_done = 1'b1;
      tick();
      tohost_done = 1'b0;
      check("tohost_irq", {63'd0, irq_out}, 64'd0);
      reg_op(1'b0, 2'd0, 64'd0, st(3, 4'hC), "tohost_status");
      drain();

      // masked interrupt still pends
      reg_op(1'b1, 2'd2, 64'd0, 64'd0, "ctrl_dis");
      pulse_edge();
      check("masked_irq", {63'd0, irq_out}, 64'd0);
      reg_op(1'b0, 2'd0, 64'd0, st(4, 4'h3), "masked_status");
      reg_op(1'b1, 2'd2, 64'd1, 64'd0, "ctrl_en");
      check("unmask_irq", {63'd0, irq_out}, 64'd1);
      clear_irq();
      drain();

      // edge and CLEAR together in IDLE: edge wins
      irq_in = 1'b0;
      repeat (3) tick();
      irq_in = 1'b1;
      repeat (2) tick();
      clear_irq();
      check("edge_wins_irq", {63'd0, irq_out}, 64'd1);
      reg_op(1'b0, 2'd0, 64'd0, st(5, 4'hB), "edge_wins_status");

      // counter wrap at 2^CNT_W
      for (int i = 0; i < 10; i++) begin
         clear_irq();
         drain();
         pulse_edge();
      end
      reg_op(1'b0, 2'd0, 64'd0, st(15, 4'hB), "count_max");
      clear_irq();
      drain();
      pulse_edge();
      reg_op(1'b0, 2'd0, 64'd0, st(0, 4'hB), "count_wrap");

      // count clear coinciding with an edge leaves count at 1
      clear_irq();
      drain();
      cov = 30'h0ABC;
      irq_in = 1'b0;
      repeat (3) tick();
      irq_in = 1'b1;
      repeat (2) tick();
      reg_op(1'b1, 2'd2, 64'd3, 64'd0, "ctrl_cnt_clr");
      reg_op(1'b0, 2'd0, 64'd0, st(1, 4'hB), "count_clr_edge");
      reg_op(1'b0, 2'd2, 64'd0, 64'd1, "ctrl_read");
      reg_op(1'b0, 2'd3, 64'd0, 64'd0, "clear_read");
      reg_op(1'b1, 2'd0, '1, 64'd0, "status_wr");
      reg_op(1'b0, 2'd1, 64'd0, 64'h0ABC, "covsnap2");
      reg_op(1'b0, 2'd0, 64'd0, st(1, 4'hB), "status_ro");

      // asynchronous reset while pending with irq_in held high
      reset_n = 1'b0;
      #1;
      check("arst_irq", {63'd0, irq_out}, 64'd0);
      check("arst_rv", {63'd0, resp_valid}, 64'd0);
      check("arst_rd", resp_rdata, 64'd0);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("rst_hold_irq", {63'd0, irq_out}, 64'd0);
      end
      reset_n = 1'b1;
      repeat (2) tick();
      check("post_rst_early", {63'd0, irq_out}, 64'd0);
      tick();
      check("post_rst_irq", {63'd0, irq_out}, 64'd1);
      reg_op(1'b0, 2'd0, 64'd0, st(1, 4'hB), "post_rst_status");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
